// File: rtl/overlay_pkg.sv
// Constants and types shared by the overlay address generator, bit repeater and mixer.
package overlay_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned V_ACTIVE_DEF = 720;
  localparam int unsigned OVL_W_DEF    = 256;
  localparam int unsigned OVL_H_DEF    = 64;
  localparam int unsigned ADDR_W_DEF   = 14;
  localparam int unsigned ROM_LAT_DEF  = 2;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = 12;

  // Video timing, pixel and window-hit flag, delayed together.
  typedef struct packed {
    logic             vs;
    logic             hs;
    logic             de;
    logic [PIX_W-1:0] pix;
    logic             hit;
  } vid_bus_t;

  // Raster counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/overlay_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module overlay_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/overlay_rom_addr_gen.sv
// Raster tracker producing overlay bitmap ROM addresses, with video timing,
// pixels and the window-hit flag delayed to line up with the ROM output.
module overlay_rom_addr_gen
  import overlay_pkg::*;
#(
  parameter int unsigned H_ACTIVE = overlay_pkg::H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = overlay_pkg::V_ACTIVE_DEF,
  parameter int unsigned OVL_W    = overlay_pkg::OVL_W_DEF,
  parameter int unsigned OVL_H    = overlay_pkg::OVL_H_DEF,
  parameter int unsigned ADDR_W   = overlay_pkg::ADDR_W_DEF,
  parameter int unsigned ROM_LAT  = overlay_pkg::ROM_LAT_DEF,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              ovl_en,
  input  logic [CNT_W-1:0]  ovl_x,
  input  logic [CNT_W-1:0]  ovl_y,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [PIX_W-1:0]  pix_out,
  output logic              ovl_hit
);

  localparam int unsigned LAT = 1 + ROM_LAT;
  localparam int unsigned XW  = $clog2(OVL_W);
  localparam int unsigned YW  = $clog2(OVL_H);
  localparam logic [CNT_W:0] OVL_W_E = OVL_W[CNT_W:0];
  localparam logic [CNT_W:0] OVL_H_E = OVL_H[CNT_W:0];

  if ((XW + YW) != ADDR_W || (1 << XW) != OVL_W || OVL_W > H_ACTIVE ||
      OVL_H > V_ACTIVE || ROM_LAT < 1 || ROM_LAT > 4) begin : g_param_check
    $error("overlay_rom_addr_gen: inconsistent parameters");
  end

  logic              vs_prev_q, de_prev_q, frame_valid_q, en_q;
  logic [CNT_W-1:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, x0_q, y0_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_rd_q;

  logic              vs_start, fv_eff, en_eff, hit;
  logic [CNT_W-1:0]  x_eff, y_eff, x0_eff, y0_eff;
  logic [XW-1:0]     dx;
  logic [YW-1:0]     dy;
  vid_bus_t          vid_in, vid_out;

  assign vs_start = (vs_in == VS_POL) && (vs_prev_q != VS_POL);

  // A vs_start pixel is evaluated as if the new frame state were already
  // loaded, so a coincident de_in pixel lands at x=0, y=0 of the new window.
  always_comb begin
    x_eff  = vs_start ? '0     : x_cnt_q;
    y_eff  = vs_start ? '0     : y_cnt_q;
    x0_eff = vs_start ? ovl_x  : x0_q;
    y0_eff = vs_start ? ovl_y  : y0_q;
    en_eff = vs_start ? ovl_en : en_q;
    fv_eff = vs_start | frame_valid_q;

    hit = fv_eff & en_eff & de_in
        & ({1'b0, x_eff} >= {1'b0, x0_eff}) & ({1'b0, x_eff} < ({1'b0, x0_eff} + OVL_W_E))
        & ({1'b0, y_eff} >= {1'b0, y0_eff}) & ({1'b0, y_eff} < ({1'b0, y0_eff} + OVL_H_E));

    dx = XW'(x_eff - x0_eff);
    dy = YW'(y_eff - y0_eff);
    rom_addr_d = hit ? {dy, dx} : '0;

    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (vs_start) begin
      x_cnt_d = de_in ? CNT_W'(1) : '0;
      y_cnt_d = '0;
    end else if (de_in) begin
      x_cnt_d = sat_inc(x_cnt_q);
    end else if (de_prev_q) begin
      x_cnt_d = '0;
      y_cnt_d = sat_inc(y_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      en_q          <= 1'b0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      rom_addr_q    <= '0;
      rom_rd_q      <= 1'b0;
    end else begin
      vs_prev_q  <= vs_in;
      de_prev_q  <= de_in;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      rom_addr_q <= rom_addr_d;
      rom_rd_q   <= hit;
      if (vs_start) begin
        frame_valid_q <= 1'b1;
        x0_q          <= ovl_x;
        y0_q          <= ovl_y;
        en_q          <= ovl_en;
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_rd   = rom_rd_q;

  assign vid_in = {vs_in, hs_in, de_in, pix_in, hit};

  overlay_delay_line #(
    .WIDTH ($bits(vid_bus_t)),
    .DEPTH (LAT)
  ) u_vid_dly (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (vid_in),
    .q_o    (vid_out)
  );

  assign vs_out  = vid_out.vs;
  assign hs_out  = vid_out.hs;
  assign de_out  = vid_out.de;
  assign pix_out = vid_out.pix;
  assign ovl_hit = vid_out.hit;

endmodule

// File: doc/overlay_rom_addr_gen.md
Name: overlay_rom_addr_gen

Overview:
- Upstream stage of the overlay bit repeater.
- Tracks raster position from the incoming HDMI video timing (vs/hs/de).
- Generates the read address for the 1-bit overlay bitmap ROM whenever the pixel falls inside the overlay window.
- Delays video timing, pixel data and a window-hit flag by the ROM latency, so the repeater output and the mixer see aligned data.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- OVL_W, 256, overlay width in pixels (power of 2)
- OVL_H, 64, overlay height in lines
- ADDR_W, 14, ROM address width (log2(OVL_W*OVL_H))
- ROM_LAT, 2, ROM read latency in clocks (1..4)
- VS_POL, 1, active level of vs_in

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vs_in  in  1  vertical sync
- hs_in  in  1  horizontal sync
- de_in  in  1  data enable (active video)
- pix_in  in  24  video pixel {R,G,B}
- ovl_en  in  1  overlay enable
- ovl_x  in  12  overlay left column
- ovl_y  in  12  overlay top line
- rom_addr  out  ADDR_W  bitmap ROM address
- rom_rd  out  1  ROM read strobe
- vs_out  out  1  vs_in delayed by LAT
- hs_out  out  1  hs_in delayed by LAT
- de_out  out  1  de_in delayed by LAT
- pix_out  out  24  pix_in delayed by LAT
- ovl_hit  out  1  pixel at output is inside the window; ROM data is valid this cycle

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: every output is 0, all counters are 0, frame_valid=0, and all pipeline stages are cleared.
- Latency: LAT = 1 + ROM_LAT.
  - Inputs sampled at cycle t produce rom_addr/rom_rd at t+1.
  - vs/hs/de/pix/ovl_hit appear at t+LAT, the same cycle the ROM bit reaches the repeater.
- Vertical sync handling:
  - Edge detect on vs_in going to VS_POL (vs_start).
  - On vs_start: y_cnt:=0, x_cnt:=0, frame_valid:=1; latch ovl_x, ovl_y, ovl_en into x0/y0/en_q.
  - Mid-frame changes to position or enable are ignored until the next vs_start.
- Horizontal counting:
  - x_cnt increments while de_in=1.
  - On the de_in falling edge: x_cnt:=0, y_cnt:=y_cnt+1.
  - Both counters are 12 bit and saturate at 4095; they never wrap.
- hs_in does not affect counting; it is only delayed.
- Hit condition:
  - hit = frame_valid & en_q & de_in & (x_cnt>=x0) & (x_cnt<x0+OVL_W) & (y_cnt>=y0) & (y_cnt<y0+OVL_H).
  - Comparisons use 13 bit arithmetic, so x0+OVL_W beyond 4095 does not wrap.
- Address and read strobe:
  - When hit: rom_addr := {(y_cnt-y0)[log2 OVL_H-1:0], (x_cnt-x0)[log2 OVL_W-1:0]} and rom_rd:=1.
  - Otherwise: rom_addr:=0 and rom_rd:=0.
- Clipping: a window extending beyond H_ACTIVE/V_ACTIVE is clipped naturally, because no de_in is asserted there. No error is raised.
- Window placement limits:
  - ovl_x=0 / ovl_y=0: the window starts at the first active pixel/line.
  - ovl_x >= H_ACTIVE: there are no hits.
- Reset mid-frame: ovl_hit stays 0 until the first vs_start after reset; video is still passed through with LAT delay.
- ovl_en=0: video passes through, and ovl_hit and rom_rd stay 0.
- Back-to-back frames: a vs_start that coincides with de_in=1 takes priority. Counters clear, and that pixel is counted as x=0, y=0.

Decomposition:
- Shared package overlay_pkg: H_ACTIVE, V_ACTIVE, OVL_W, OVL_H, ADDR_W, ROM_LAT defaults, and the pixel width constant (24). The bit repeater and mixer use the same package.
- One sub-module: overlay_delay_line (params WIDTH, DEPTH; async active-low reset to 0). It is instantiated once for the {vs,hs,de,pix,hit} bundle, at WIDTH 28 and DEPTH LAT.

Test Plan:
- Reset then passthrough: rst_n low for 5 clk, drive 1280x720 timing with ovl_en=0 → outputs equal inputs delayed exactly 3 clk (ROM_LAT=2); rom_rd and ovl_hit stay 0.
- Addressing: ovl_x=100, ovl_y=50, ovl_en=1, then vs_start → on line 50 the first rom_rd=1 is at pixel 100 with addr 0, pixel 355 has addr 255, pixel 356 has rom_rd=0; line 51 pixel 100 has addr 256; line 113 pixel 355 has addr 16383; line 114 has no hits.
- Alignment: a model ROM with 2-clk latency is connected → ovl_hit=1 exactly on the cycles the ROM data is valid and de_out=1, for the full 256x64 window (16384 hits per frame).
- Clipping: ovl_x=1200, ovl_y=700 → per line, hits only at x=1200..1279 (80 hits); only 20 lines hit; max addr is 19*256+79=4943.
- Mid-frame change: change ovl_x 100→400 on line 10 → the current frame still hits at x=100, and the next frame hits at x=400.
- Reset mid-frame: assert rst_n low at line 60 → outputs are 0 immediately (async); after release, no hits until the next vs_start, then normal hits resume.
